// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - duty-cycle sequencer (off/static/breathe/blink) for pwm_led
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   enable        run; low forces everything idle on the next edge
//   mode          00 off, 01 static, 10 breathe, 11 blink
//   static_duty   static level and blink on-level
//   step_size     ramp increment per step (0 behaves as 1)
//   duty_cycle    registered duty to pwm_led, changes only on period boundaries
//   period_start  one-cycle pulse in the cycle following each period wrap
//   ramp_dir      1 while ramping down
module pwm_duty_sequencer #(
    parameter int PERIOD   = 256,
    parameter int STEP_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [7:0] static_duty,
    input  logic [7:0] step_size,
    output logic [7:0] duty_cycle,
    output logic       period_start,
    output logic       ramp_dir
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_DIV - 1);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_STATIC  = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_BLINK   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_STATIC, S_UP, S_DOWN, S_BLINK_ON, S_BLINK_OFF
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      duty_q, duty_d;
    logic [PW-1:0]   period_cnt_q, period_cnt_d;
    logic [SW-1:0]   step_cnt_q, step_cnt_d;
    logic            period_start_q;
    logic            ramp_dir_q;

    logic            ptick;
    logic            stick;
    logic [7:0]      step_eff;
    logic [8:0]      up_sum;

    assign ptick    = (period_cnt_q == PERIOD_LAST) && enable;
    assign stick    = ptick && (step_cnt_q == STEP_LAST);
    assign step_eff = (step_size == 8'd0) ? 8'd1 : step_size;
    // 9-bit sum so the saturation test sees the carry instead of a wrapped value
    assign up_sum   = {1'b0, duty_q} + {1'b0, step_eff};

    // Mode value that keeps a state where it is; any other sampled mode re-enters
    function automatic logic [1:0] family(input state_t s);
        case (s)
            S_STATIC:                family = MODE_STATIC;
            S_UP, S_DOWN:            family = MODE_BREATHE;
            S_BLINK_ON, S_BLINK_OFF: family = MODE_BLINK;
            default:                 family = MODE_OFF;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        period_cnt_d = period_cnt_q;
        step_cnt_d   = step_cnt_q;
        if (!enable) begin
            state_d      = S_IDLE;
            duty_d       = 8'd0;
            period_cnt_d = '0;
            step_cnt_d   = '0;
        end else if (ptick) begin
            period_cnt_d = '0;
            step_cnt_d   = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + SW'(1);
            // A mode change takes priority over a step falling on the same edge
            if (mode != family(state_q)) begin
                case (mode)
                    MODE_OFF: begin
                        state_d = S_IDLE;
                        duty_d  = 8'd0;
                    end
                    MODE_STATIC: begin
                        state_d = S_STATIC;
                        duty_d  = static_duty;
                    end
                    MODE_BREATHE: begin
                        state_d = S_UP;
                    end
                    default: begin
                        // Restart the step timebase so the first on-phase is full length
                        state_d    = S_BLINK_ON;
                        duty_d     = static_duty;
                        step_cnt_d = '0;
                    end
                endcase
            end else begin
                case (state_q)
                    S_STATIC: duty_d = static_duty;
                    S_UP: begin
                        if (stick) begin
                            if (up_sum >= 9'd255) begin
                                duty_d  = 8'd255;
                                state_d = S_DOWN;
                            end else begin
                                duty_d = up_sum[7:0];
                            end
                        end
                    end
                    S_DOWN: begin
                        if (stick) begin
                            if (duty_q <= step_eff) begin
                                duty_d  = 8'd0;
                                state_d = S_UP;
                            end else begin
                                duty_d = duty_q - step_eff;
                            end
                        end
                    end
                    S_BLINK_ON: begin
                        if (stick) begin
                            state_d = S_BLINK_OFF;
                            duty_d  = 8'd0;
                        end
                    end
                    S_BLINK_OFF: begin
                        if (stick) begin
                            state_d = S_BLINK_ON;
                            duty_d  = static_duty;
                        end
                    end
                    default: duty_d = 8'd0;
                endcase
            end
        end else begin
            period_cnt_d = period_cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            duty_q         <= 8'd0;
            period_cnt_q   <= '0;
            step_cnt_q     <= '0;
            period_start_q <= 1'b0;
            ramp_dir_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            duty_q         <= duty_d;
            period_cnt_q   <= period_cnt_d;
            step_cnt_q     <= step_cnt_d;
            period_start_q <= ptick;
            ramp_dir_q     <= (state_d == S_DOWN);
        end
    end

    assign duty_cycle   = duty_q;
    assign period_start = period_start_q;
    assign ramp_dir     = ramp_dir_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - bench for pwm_duty_sequencer (PERIOD=16, STEP_DIV=2)
module tb_pwm_duty_sequencer;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] static_duty;
    logic [7:0] step_size;
    logic [7:0] duty_cycle;
    logic       period_start;
    logic       ramp_dir;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] duty;
        logic       ramp;
        int         dt;
    } exp_t;

    exp_t exp_q[$];

    pwm_duty_sequencer #(.PERIOD(16), .STEP_DIV(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .mode         (mode),
        .static_duty  (static_duty),
        .step_size    (step_size),
        .duty_cycle   (duty_cycle),
        .period_start (period_start),
        .ramp_dir     (ramp_dir)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input logic [7:0] d, input logic r, input int t);
        exp_t e;
        e.duty = d;
        e.ramp = r;
        e.dt   = t;
        exp_q.push_back(e);
    endtask

    // Wait for the next duty change; dt counts edges from the call
    task automatic observe_change(input int budget, output logic got, output int dt,
                                  output logic ps);
        logic [7:0] prev;
        prev = duty_cycle;
        got  = 1'b0;
        dt   = 0;
        ps   = 1'b0;
        while (!got && dt < budget) begin
            @(posedge clk);
            #1;
            dt++;
            if (duty_cycle !== prev) begin
                got = 1'b1;
                ps  = period_start;
            end
        end
    endtask

    task automatic wait_ps(input int budget, output logic got, output int dt);
        got = 1'b0;
        dt  = 0;
        while (!got && dt < budget) begin
            @(posedge clk);
            #1;
            dt++;
            if (period_start === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic got;
        int   dt;
        reset_n = 1'b1; enable = 1'b0; mode = 2'b00; static_duty = 8'd0; step_size = 8'd0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (duty_cycle !== 8'd0 || period_start !== 1'b0 || ramp_dir !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: duty=%0d ps=%0b ramp=%0b want 0/0/0",
                     duty_cycle, period_start, ramp_dir);
        end
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_ps(100, got, dt);
        total++;
        if (!got || dt != 16 || duty_cycle !== 8'd0) begin
            bad++;
            $display("FAIL first_period_start: got=%0b dt=%0d duty=%0d want dt=16 duty=0",
                     got, dt, duty_cycle);
        end
    endtask

    task automatic test_static();
        logic got, ps;
        int   dt;
        exp_t e;
        mode = 2'b01; static_duty = 8'd64;
        push_exp(8'd64, 1'b0, 16);
        push_exp(8'd192, 1'b0, 11);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                repeat (5) @(posedge clk);
                #1;
                static_duty = 8'd192;
            end
            e = exp_q.pop_front();
            observe_change(100, got, dt, ps);
            total++;
            if (!got || duty_cycle !== e.duty || ramp_dir !== e.ramp || dt != e.dt || ps !== 1'b1) begin
                bad++;
                $display("FAIL static[%0d]: got=%0b duty=%0d ramp=%0b dt=%0d ps=%0b want duty=%0d ramp=%0b dt=%0d ps=1",
                         i, got, duty_cycle, ramp_dir, dt, ps, e.duty, e.ramp, e.dt);
            end
        end
    endtask

    task automatic test_breathe();
        logic got, ps;
        int   dt;
        int   n;
        exp_t e;
        logic [7:0] seq [9];
        logic       dir [9];
        seq = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd191, 8'd127, 8'd63, 8'd0, 8'd64};
        dir = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        mode = 2'b00;
        push_exp(8'd0, 1'b0, 16);
        n = 0;
        while (exp_q.size() > 0) begin
            if (n == 1) begin
                mode = 2'b10; step_size = 8'd64;
            end
            e = exp_q.pop_front();
            observe_change(100, got, dt, ps);
            total++;
            if (!got || duty_cycle !== e.duty || ramp_dir !== e.ramp || dt != e.dt || ps !== 1'b1) begin
                bad++;
                $display("FAIL breathe[%0d]: got=%0b duty=%0d ramp=%0b dt=%0d ps=%0b want duty=%0d ramp=%0b dt=%0d ps=1",
                         n, got, duty_cycle, ramp_dir, dt, ps, e.duty, e.ramp, e.dt);
            end
            if (n == 0) begin
                for (int i = 0; i < 9; i++) push_exp(seq[i], dir[i], 32);
            end
            n++;
        end
    endtask

    task automatic test_step_edges();
        logic got, ps;
        int   dt;
        int   n;
        exp_t e;
        step_size = 8'd0;
        push_exp(8'd65, 1'b0, 32);
        push_exp(8'd66, 1'b0, 32);
        push_exp(8'd255, 1'b1, 32);
        push_exp(8'd0, 1'b0, 32);
        push_exp(8'd255, 1'b1, 32);
        n = 0;
        while (exp_q.size() > 0) begin
            if (n == 2) step_size = 8'd255;
            e = exp_q.pop_front();
            observe_change(100, got, dt, ps);
            total++;
            if (!got || duty_cycle !== e.duty || ramp_dir !== e.ramp || dt != e.dt || ps !== 1'b1) begin
                bad++;
                $display("FAIL step_edge[%0d]: got=%0b duty=%0d ramp=%0b dt=%0d ps=%0b want duty=%0d ramp=%0b dt=%0d ps=1",
                         n, got, duty_cycle, ramp_dir, dt, ps, e.duty, e.ramp, e.dt);
            end
            n++;
        end
    endtask

    task automatic test_blink();
        logic got, ps;
        int   dt;
        int   n;
        exp_t e;
        mode = 2'b11; static_duty = 8'd200;
        push_exp(8'd200, 1'b0, 16);
        push_exp(8'd0, 1'b0, 32);
        push_exp(8'd200, 1'b0, 32);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            observe_change(100, got, dt, ps);
            total++;
            if (!got || duty_cycle !== e.duty || ramp_dir !== e.ramp || dt != e.dt || ps !== 1'b1) begin
                bad++;
                $display("FAIL blink[%0d]: got=%0b duty=%0d ramp=%0b dt=%0d ps=%0b want duty=%0d ramp=%0b dt=%0d ps=1",
                         n, got, duty_cycle, ramp_dir, dt, ps, e.duty, e.ramp, e.dt);
            end
            n++;
        end
    endtask

    task automatic test_disable();
        logic got;
        int   dt;
        int   ps_seen;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (duty_cycle !== 8'd0 || period_start !== 1'b0 || ramp_dir !== 1'b0) begin
            bad++;
            $display("FAIL disable_now: duty=%0d ps=%0b ramp=%0b want 0/0/0",
                     duty_cycle, period_start, ramp_dir);
        end
        ps_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (period_start !== 1'b0 || duty_cycle !== 8'd0) ps_seen++;
        end
        total++;
        if (ps_seen != 0) begin
            bad++;
            $display("FAIL disable_silent: active_cycles=%0d want 0", ps_seen);
        end
        mode = 2'b01; static_duty = 8'd77; enable = 1'b1;
        push_exp(8'd77, 1'b0, 16);
        wait_ps(100, got, dt);
        total++;
        if (!got || dt != exp_q[0].dt || duty_cycle !== exp_q[0].duty) begin
            bad++;
            $display("FAIL reenable_static: got=%0b dt=%0d duty=%0d want dt=%0d duty=%0d",
                     got, dt, duty_cycle, exp_q[0].dt, exp_q[0].duty);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_async_reset();
        logic got, ps;
        int   dt;
        int   n;
        exp_t e;
        // Entry edge is also a step edge: the mode change consumes it, so +48
        mode = 2'b10; step_size = 8'd64;
        push_exp(8'd141, 1'b0, 48);
        push_exp(8'd205, 1'b0, 32);
        push_exp(8'd255, 1'b1, 32);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            observe_change(100, got, dt, ps);
            total++;
            if (!got || duty_cycle !== e.duty || ramp_dir !== e.ramp || dt != e.dt || ps !== 1'b1) begin
                bad++;
                $display("FAIL ramp_before_reset[%0d]: got=%0b duty=%0d ramp=%0b dt=%0d ps=%0b want duty=%0d ramp=%0b dt=%0d ps=1",
                         n, got, duty_cycle, ramp_dir, dt, ps, e.duty, e.ramp, e.dt);
            end
            n++;
        end
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        total++;
        if (duty_cycle !== 8'd0 || period_start !== 1'b0 || ramp_dir !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: duty=%0d ps=%0b ramp=%0b want 0/0/0",
                     duty_cycle, period_start, ramp_dir);
        end
        #20 reset_n = 1'b1;
        wait_ps(100, got, dt);
        total++;
        if (!got || dt != 16 || duty_cycle !== 8'd0 || ramp_dir !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got=%0b dt=%0d duty=%0d ramp=%0b want dt=16 duty=0 ramp=0",
                     got, dt, duty_cycle, ramp_dir);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_breathe();
        test_step_edges();
        test_blink();
        test_disable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
